// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter/sequencer for a synchronous dmem.
// Ports: clk/RESET (async active-low); per port reqN/weN/addrN/wdataN in,
// gntN/doneN pulses and rdataN out; mem_* drive dmem, mem_dout is its
// registered read data; busy is high while an access is in flight.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [AW-1:0]         addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [AW-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  // last_q: port granted most recently (1 after reset so port 0 wins the first tie)
  logic last_q, last_d, win_q, win_d, wr_q, wr_d, win;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic mem_write_q, mem_write_d, mem_read_q, mem_read_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d, wdat_q, wdat_d;
  logic [AW-1:0] addr_q, addr_d;
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    busy_d      = busy_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    win         = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d     = ISSUE;
        last_d      = win;
        win_d       = win;
        wr_d        = win ? we1 : we0;
        addr_d      = win ? addr1 : addr0;
        wdat_d      = win ? wdata1 : wdata0;
        gnt0_d      = ~win;
        gnt1_d      = win;
        mem_write_d = win ? we1 : we0;
        mem_read_d  = win ? ~we1 : ~we0;
        busy_d      = 1'b1;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done0_d  = ~win_q;
        done1_d  = win_q;
        rdata0_d = (!wr_q && !win_q) ? mem_dout : rdata0_q;
        rdata1_d = (!wr_q && win_q) ? mem_dout : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end
  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign done0          = done0_q;
  assign done1          = done1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdat_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random accesses checked against a transaction-level model.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic RESET = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, done0, gnt1, done1, mem_write, mem_read, busy;
  logic [DW-1:0] rdata0, rdata1, mem_write_data, mem_dout;
  logic [AW-1:0] mem_addr;
  logic dmem_rst = 1'b1;
  logic [DW-1:0] dmem [DEPTH];
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] ref_mem [int];
  bit ref_last;
  logic [DW-1:0] exp_rd0, exp_rd1;
  bit rr0, rr1, rw0, rw1;
  logic [AW-1:0] ra0, ra1;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .RESET(RESET),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_dout(mem_dout), .busy(busy)
  );

  // synchronous dmem: resets to all ones, registered read data
  always @(posedge clk) begin
    if (dmem_rst) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '1;
    end else begin
      if (mem_write) dmem[mem_addr] <= mem_write_data;
      if (mem_read) mem_dout <= dmem[mem_addr];
    end
  end

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '1;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_last = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  // Starts with the DUT idle; drives one request pattern and follows it to completion.
  task automatic access(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit win, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (!r0 && !r1) begin
      @(posedge clk); #1;
      chk("idle_gnt0", gnt0, 0);
      chk("idle_gnt1", gnt1, 0);
      chk("idle_busy", busy, 0);
      return;
    end
    win = (r0 && r1) ? !ref_last : r1;
    ref_last = win;
    wr = win ? w1 : w0;
    a = win ? a1 : a0;
    d = win ? d1 : d0;
    @(posedge clk); #1;
    chk("gnt0", gnt0, !win);
    chk("gnt1", gnt1, win);
    chk("issue_busy", busy, 1);
    chk("issue_mem_write", mem_write, wr);
    chk("issue_mem_read", mem_read, !wr);
    chk("issue_mem_addr", mem_addr, a);
    chk("issue_mem_wdata", mem_write_data, d);
    @(posedge clk); #1;
    chk("wait_gnt", {gnt0, gnt1}, 0);
    chk("wait_mem_ctl", {mem_write, mem_read}, 0);
    chk("wait_done", {done0, done1}, 0);
    chk("wait_busy", busy, 1);
    if (wr) ref_mem[int'(a)] = d;
    else if (win) exp_rd1 = ref_read(int'(a));
    else exp_rd0 = ref_read(int'(a));
    @(posedge clk); #1;
    chk("done0", done0, !win);
    chk("done1", done1, win);
    chk("rdata0", rdata0, exp_rd0);
    chk("rdata1", rdata1, exp_rd1);
    chk("done_busy", busy, 0);
    chk("done_mem_addr", mem_addr, a);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulses", {gnt0, gnt1, done0, done1, mem_write, mem_read, busy}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    dmem_rst = 1'b0;
    RESET = 1'b1;
    access(0, 0, 0, 0, 0, 0, 0, 0);
    // read of reset memory
    access(1, 0, 5, 0, 0, 0, 0, 0);
    // write from port 1 then read back from port 0
    access(0, 0, 0, 0, 1, 1, 10, 32'hDEADBEEF);
    access(1, 0, 10, 0, 0, 0, 0, 0);
    // preload distinct words for the alternating-grant reads
    for (int i = 0; i < 4; i++) begin
      access(1, 1, AW'(20 + i), 32'h100 + i, 0, 0, 0, 0);
      access(0, 0, 0, 0, 1, 1, AW'(40 + i), 32'h200 + i);
    end
    // reset so the continuous tie starts from port 0
    RESET = 1'b0;
    @(posedge clk); #1;
    RESET = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) access(1, 0, AW'(20 + i / 2), 0, 1, 0, AW'(40 + i / 2), 0);
    // back-to-back writes then read to the same address
    access(1, 1, 3, 32'h1, 0, 0, 0, 0);
    access(1, 1, 3, 32'h2, 0, 0, 0, 0);
    access(1, 0, 3, 0, 0, 0, 0, 0);
    // reset dropped during the wait cycle of a port-1 read
    req0 = 0; req1 = 1; we1 = 0; addr1 = 7;
    @(posedge clk); #1;
    chk("abort_gnt1", gnt1, 1);
    req1 = 0;
    @(posedge clk); #1;
    RESET = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {gnt0, gnt1, done0, done1, mem_write, mem_read}, 0);
    chk("abort_rdata1", rdata1, 0);
    chk("abort_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    chk("abort_no_done1", done1, 0);
    RESET = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("abort_no_done1_late", done1, 0);
    access(1, 0, 20, 0, 1, 0, 40, 0);
    // port 1 read then write to the top address; rdata1 must stay
    access(0, 0, 0, 0, 1, 0, 41, 0);
    access(0, 0, 0, 0, 1, 1, AW'(DEPTH - 1), 32'hCAFEF00D);
    access(1, 0, AW'(DEPTH - 1), 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 60; i++) begin
      rr0 = bit'($urandom_range(0, 1));
      rr1 = bit'($urandom_range(0, 1));
      rw0 = bit'($urandom_range(0, 1));
      rw1 = bit'($urandom_range(0, 1));
      ra0 = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
      ra1 = AW'($urandom_range(0, 15));
      access(rr0, rw0, ra0, $urandom, rr1, rw1, ra1, $urandom);
    end
    access(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
